// File: rtl/pll_sup_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pll_sup_pkg
//  Purpose  : Shared definitions for the PLL lock supervisor: FSM state
//             encoding and the constant helpers used to size its counter.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package pll_sup_pkg;

    localparam logic [2:0] PLL_RST   = 3'd0;
    localparam logic [2:0] WAIT_LOCK = 3'd1;
    localparam logic [2:0] STABILIZE = 3'd2;
    localparam logic [2:0] RUN       = 3'd3;
    localparam logic [2:0] FAULT     = 3'd4;

    typedef enum logic [2:0] {
        S_PLL_RST   = PLL_RST,
        S_WAIT_LOCK = WAIT_LOCK,
        S_STABILIZE = STABILIZE,
        S_RUN       = RUN,
        S_FAULT     = FAULT
    } sup_state_t;

    // Bits needed to hold values 0 .. value-1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_2ff
//  Purpose  : 1-bit two-flop synchronizer for asynchronous level flags.
//  Ports    : clk  - destination clock
//             rst  - asynchronous active-high reset (output forced to 0)
//             i_d  - asynchronous input flag
//             o_q  - flag synchronized to clk (2-edge latency)
//  Revision : 1.0  initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
//  Module   : pll_lock_supervisor
//  Purpose  : Drives the PLL reset from the reference clock, qualifies the
//             asynchronous lock flag, and releases the design reset only
//             after lock has been stable. Retries a bounded number of times
//             and latches a fault if lock is never achieved.
//  Ports    : clock       - 50 MHz reference clock
//             reset       - asynchronous active-high reset
//             pll_locked  - PLL lock flag (asynchronous)
//             pll_rst     - PLL reset, active-high
//             sys_reset   - reset for PLL-clocked logic, active-high
//             ready       - lock-qualified and sys_reset released
//             fault       - sticky, retry budget exhausted
//             lock_lost   - one-cycle pulse on loss of lock while running
//             retry_count - timed-out attempts since last successful run
//  Revision : 1.0  initial release
// ============================================================================
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES    = 7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       ready,
    output logic       fault,
    output logic       lock_lost,
    output logic [2:0] retry_count
);

    localparam int CNT_W = clog2(max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));

    localparam logic [CNT_W-1:0] c_RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [2:0]       c_MAX_RETRIES = 3'(MAX_RETRIES);

    logic             w_locked_s;

    sup_state_t       r_state;
    sup_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_retry;
    logic [2:0]       w_retry_nxt;
    logic             w_lock_lost_nxt;

    logic             r_pll_rst;
    logic             r_sys_reset;
    logic             r_ready;
    logic             r_fault;
    logic             r_lock_lost;

    sync_2ff u_lock_sync (
        .clk (clock),
        .rst (reset),
        .i_d (pll_locked),
        .o_q (w_locked_s)
    );

    // State register and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_PLL_RST;
            r_cnt       <= '0;
            r_retry     <= 3'd0;
            r_pll_rst   <= 1'b1;
            r_sys_reset <= 1'b1;
            r_ready     <= 1'b0;
            r_fault     <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_retry     <= w_retry_nxt;
            // Outputs are decoded from the next state so they change on the
            // same edge as the state itself.
            r_pll_rst   <= (w_state_nxt == S_PLL_RST);
            r_sys_reset <= (w_state_nxt != S_RUN);
            r_ready     <= (w_state_nxt == S_RUN);
            r_fault     <= (w_state_nxt == S_FAULT);
            r_lock_lost <= w_lock_lost_nxt;
        end
    end

    // Next-state logic. Lock-drop checks come before the counter matches so
    // a drop coincident with a timeout/stable match wins.
    always_comb begin
        w_state_nxt     = r_state;
        w_retry_nxt     = r_retry;
        w_lock_lost_nxt = 1'b0;

        case (r_state)
            S_PLL_RST: begin
                if (r_cnt == c_RST_LAST) begin
                    w_state_nxt = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                if (w_locked_s) begin
                    w_state_nxt = S_STABILIZE;
                end else if (r_cnt == c_TIMEOUT_LAST) begin
                    if (r_retry == c_MAX_RETRIES) begin
                        w_state_nxt = S_FAULT;
                    end else begin
                        w_retry_nxt = r_retry + 3'd1;
                        w_state_nxt = S_PLL_RST;
                    end
                end
            end
            S_STABILIZE: begin
                // A short dropout just restarts the lock wait without
                // re-resetting the PLL or consuming a retry.
                if (!w_locked_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                end else if (r_cnt == c_STABLE_LAST) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!w_locked_s) begin
                    w_state_nxt     = S_PLL_RST;
                    w_lock_lost_nxt = 1'b1;
                    w_retry_nxt     = 3'd0;
                end
            end
            S_FAULT: begin
                w_state_nxt = S_FAULT;
            end
            default: begin
                w_state_nxt = S_PLL_RST;
            end
        endcase

        // Shared counter: cleared on any state change, otherwise counts in
        // the timed states and idles at zero in RUN/FAULT.
        if (w_state_nxt != r_state) begin
            w_cnt_nxt = '0;
        end else if ((r_state == S_PLL_RST) || (r_state == S_WAIT_LOCK) ||
                     (r_state == S_STABILIZE)) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end else begin
            w_cnt_nxt = '0;
        end
    end

    assign pll_rst     = r_pll_rst;
    assign sys_reset   = r_sys_reset;
    assign ready       = r_ready;
    assign fault       = r_fault;
    assign lock_lost   = r_lock_lost;
    assign retry_count = r_retry;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pll_lock_supervisor
//  Purpose  : Self-checking bench for pll_lock_supervisor with reduced
//             timing parameters.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pll_lock_supervisor;

    localparam int P_RST = 4;
    localparam int P_TO  = 64;
    localparam int P_ST  = 16;
    localparam int P_MR  = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_reset;
    logic       ready;
    logic       fault;
    logic       lock_lost;
    logic [2:0] retry_count;

    pll_lock_supervisor #(
        .PLL_RST_CYCLES (P_RST),
        .LOCK_TIMEOUT   (P_TO),
        .STABLE_CYCLES  (P_ST),
        .MAX_RETRIES    (P_MR)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .pll_locked  (pll_locked),
        .pll_rst     (pll_rst),
        .sys_reset   (sys_reset),
        .ready       (ready),
        .fault       (fault),
        .lock_lost   (lock_lost),
        .retry_count (retry_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [31:0] value;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // {pll_rst, sys_reset, ready, fault, lock_lost, retry_count}
    localparam logic [31:0] c_RESET_OUTS = 32'hC0;

    function automatic logic [31:0] outs();
        return {24'd0, pll_rst, sys_reset, ready, fault, lock_lost, retry_count};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Hold reset for two edges with lock low, release between edges.
    task automatic apply_reset();
        reset      = 1'b1;
        pll_locked = 1'b0;
        tick();
        tick();
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Edges from the first sampling edge (E0) until ready is seen high.
    task automatic measure_ready(output int lat, output logic [2:0] rc_mid);
        lat    = -1;
        rc_mid = 3'd7;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (i == 10) rc_mid = retry_count;
            if (ready) begin
                lat = i - 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        exp_t e;
        reset      = 1'b1;
        pll_locked = 1'b0;
        sb.push_back('{name: "reset_outputs", value: c_RESET_OUTS});
        tick();
        tick();
        e = sb.pop_front();
        n_tests++;
        if (outs() !== e.value) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", e.name, outs(), e.value);
        end
    endtask

    task automatic test_lock_normal();
        exp_t       e;
        int         obs;
        logic [2:0] rc;
        apply_reset();
        sb.push_back('{name: "pll_rst_width", value: P_RST});
        obs = -1;
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (!pll_rst) begin
                obs = i;
                break;
            end
        end
        e = sb.pop_front();
        n_tests++;
        if (obs !== int'(e.value)) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", e.name, obs, e.value);
        end
        repeat (10 - P_RST) tick();
        @(negedge clock);
        pll_locked = 1'b1;
        sb.push_back('{name: "lock_to_ready", value: P_ST + 2});
        sb.push_back('{name: "normal_retry", value: 0});
        sb.push_back('{name: "normal_sys_reset", value: 0});
        measure_ready(obs, rc);
        e = sb.pop_front();
        n_tests++;
        if (obs !== int'(e.value)) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", e.name, obs, e.value);
        end
        e = sb.pop_front();
        n_tests++;
        if ({29'd0, retry_count} !== e.value) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", e.name, retry_count, e.value);
        end
        e = sb.pop_front();
        n_tests++;
        if ({31'd0, sys_reset} !== e.value) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", e.name, sys_reset, e.value);
        end
    endtask

    task automatic test_timeout_fault();
        exp_t e;
        int   rise_edge [2];
        int   rise_rc   [2];
        int   n_rise;
        int   fault_edge;
        logic prev_rst;
        apply_reset();
        sb.push_back('{name: "retry1_edge", value: P_RST + P_TO});
        sb.push_back('{name: "retry1_count", value: 1});
        sb.push_back('{name: "retry2_edge", value: 2 * (P_RST + P_TO)});
        sb.push_back('{name: "retry2_count", value: 2});
        sb.push_back('{name: "fault_edge", value: (P_MR + 1) * (P_RST + P_TO)});
        rise_edge  = '{-1, -1};
        rise_rc    = '{-1, -1};
        n_rise     = 0;
        fault_edge = -1;
        prev_rst   = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            tick();
            if (pll_rst && !prev_rst && n_rise < 2) begin
                rise_edge[n_rise] = k;
                rise_rc[n_rise]   = int'(retry_count);
                n_rise++;
            end
            prev_rst = pll_rst;
            if (fault) begin
                fault_edge = k;
                break;
            end
        end
        for (int j = 0; j < 2; j++) begin
            e = sb.pop_front();
            n_tests++;
            if (rise_edge[j] !== int'(e.value)) begin
                n_fail++;
                $display("FAIL %s: got %0d, expected %0d", e.name, rise_edge[j], e.value);
            end
            e = sb.pop_front();
            n_tests++;
            if (rise_rc[j] !== int'(e.value)) begin
                n_fail++;
                $display("FAIL %s: got %0d, expected %0d", e.name, rise_rc[j], e.value);
            end
        end
        e = sb.pop_front();
        n_tests++;
        if (fault_edge !== int'(e.value)) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", e.name, fault_edge, e.value);
        end
        // Lock arriving late must not rescue a fault.
        @(negedge clock);
        pll_locked = 1'b1;
        sb.push_back('{name: "fault_sticky_outs", value: 32'h52});
        repeat (50) tick();
        e = sb.pop_front();
        n_tests++;
        if (outs() !== e.value) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", e.name, outs(), e.value);
        end
        sb.push_back('{name: "fault_cleared_by_reset", value: c_RESET_OUTS});
        reset = 1'b1;
        #1;
        e = sb.pop_front();
        n_tests++;
        if (outs() !== e.value) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", e.name, outs(), e.value);
        end
    endtask

    task automatic test_glitch_and_loss();
        exp_t e;
        int   n_rst;
        int   n_rc;
        int   n_rdy;
        int   lat;
        int   drop_edge;
        int   n_pulse;
        int   n_rst2;
        logic [31:0] at_drop;
        apply_reset();
        repeat (10) tick();
        @(negedge clock);
        pll_locked = 1'b1;
        n_rst = 0;
        n_rc  = 0;
        n_rdy = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (pll_rst) n_rst++;
            if (retry_count != 3'd0) n_rc++;
            if (ready) n_rdy++;
        end
        @(negedge clock);
        pll_locked = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (pll_rst) n_rst++;
            if (retry_count != 3'd0) n_rc++;
            if (ready) n_rdy++;
        end
        @(negedge clock);
        pll_locked = 1'b1;
        sb.push_back('{name: "glitch_ready_latency", value: P_ST + 2});
        sb.push_back('{name: "glitch_pll_rst_samples", value: 0});
        sb.push_back('{name: "glitch_retry_nonzero", value: 0});
        sb.push_back('{name: "glitch_early_ready", value: 0});
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (pll_rst) n_rst++;
            if (retry_count != 3'd0) n_rc++;
            if (ready) begin
                lat = i - 1;
                break;
            end
        end
        e = sb.pop_front();
        n_tests++;
        if (lat !== int'(e.value)) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", e.name, lat, e.value);
        end
        e = sb.pop_front();
        n_tests++;
        if (n_rst !== int'(e.value)) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", e.name, n_rst, e.value);
        end
        e = sb.pop_front();
        n_tests++;
        if (n_rc !== int'(e.value)) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", e.name, n_rc, e.value);
        end
        e = sb.pop_front();
        n_tests++;
        if (n_rdy !== int'(e.value)) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", e.name, n_rdy, e.value);
        end

        // Now in RUN: drop lock.
        @(negedge clock);
        pll_locked = 1'b0;
        sb.push_back('{name: "loss_edge", value: 3});
        sb.push_back('{name: "loss_outs", value: 32'hC8});
        sb.push_back('{name: "loss_pulse_count", value: 1});
        sb.push_back('{name: "loss_pll_rst_width", value: P_RST});
        drop_edge = -1;
        at_drop   = '1;
        n_pulse   = 0;
        n_rst2    = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (!ready && drop_edge < 0) begin
                drop_edge = i;
                at_drop   = outs();
            end
            if (lock_lost) n_pulse++;
            if (pll_rst) n_rst2++;
        end
        e = sb.pop_front();
        n_tests++;
        if (drop_edge !== int'(e.value)) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", e.name, drop_edge, e.value);
        end
        e = sb.pop_front();
        n_tests++;
        if (at_drop !== e.value) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", e.name, at_drop, e.value);
        end
        e = sb.pop_front();
        n_tests++;
        if (n_pulse !== int'(e.value)) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", e.name, n_pulse, e.value);
        end
        e = sb.pop_front();
        n_tests++;
        if (n_rst2 !== int'(e.value)) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", e.name, n_rst2, e.value);
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        apply_reset();
        repeat (10) tick();
        @(negedge clock);
        pll_locked = 1'b1;
        repeat (8) tick();
        sb.push_back('{name: "stabilize_outs", value: 32'h40});
        sb.push_back('{name: "async_reset_outs", value: c_RESET_OUTS});
        e = sb.pop_front();
        n_tests++;
        if (outs() !== e.value) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", e.name, outs(), e.value);
        end
        #2;
        reset = 1'b1;
        #1;
        e = sb.pop_front();
        n_tests++;
        if (outs() !== e.value) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", e.name, outs(), e.value);
        end
        tick();
    endtask

    task automatic test_timeout_then_lock();
        exp_t       e;
        int         lat;
        logic [2:0] rc;
        apply_reset();
        for (int i = 0; i < 200; i++) begin
            tick();
            if (retry_count == 3'd1) break;
        end
        repeat (10) tick();
        @(negedge clock);
        pll_locked = 1'b1;
        sb.push_back('{name: "tl_ready_latency", value: P_ST + 2});
        sb.push_back('{name: "tl_retry_in_stabilize", value: 1});
        measure_ready(lat, rc);
        e = sb.pop_front();
        n_tests++;
        if (lat !== int'(e.value)) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", e.name, lat, e.value);
        end
        e = sb.pop_front();
        n_tests++;
        if ({29'd0, rc} !== e.value) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", e.name, rc, e.value);
        end
        @(negedge clock);
        pll_locked = 1'b0;
        sb.push_back('{name: "tl_loss_outs", value: 32'hC8});
        repeat (3) tick();
        e = sb.pop_front();
        n_tests++;
        if (outs() !== e.value) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", e.name, outs(), e.value);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        pll_locked = 1'b0;
        test_reset();
        test_lock_normal();
        test_timeout_fault();
        test_glitch_and_loss();
        test_async_reset();
        test_timeout_then_lock();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
